// File: rtl/store_queue_be_if.sv
// Store-path bundle between the MEM stage / data bus and store_queue_be.
// The queue is the slave; the surrounding pipeline and bus model take the master view.
interface store_queue_be_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              st_valid;
    logic [1:0]        st_size;
    logic [31:0]       st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ovf;
    logic              st_ready;
    logic              exc_ades;
    logic              flush;
    logic              mem_valid;
    logic              mem_ready;
    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [LANES-1:0]  mem_byteen;
    logic [CNT_W-1:0]  count;

    modport master (
        output st_valid, st_size, st_addr, st_data, st_ovf, flush, mem_ready,
        input  st_ready, exc_ades, mem_valid, mem_addr, mem_wdata, mem_byteen, count
    );

    modport slave (
        input  st_valid, st_size, st_addr, st_data, st_ovf, flush, mem_ready,
        output st_ready, exc_ades, mem_valid, mem_addr, mem_wdata, mem_byteen, count
    );
endinterface

// File: rtl/store_queue_be.sv
// Checked, lane-aligned store FIFO: address-checks each store, forms byte enables
// and shifted data, queues legal stores and drains them in order to the data bus.
module store_queue_be #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] DM_END   = 32'h0000_2fff,
    parameter logic [31:0] TC0_BASE = 32'h0000_7f00,
    parameter logic [31:0] TC1_BASE = 32'h0000_7f10,
    parameter logic [31:0] INS_BASE = 32'h0000_7f20
) (
    input logic             clk,
    input logic             reset,
    store_queue_be_if.slave bus
);
    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned LSB   = $clog2(LANES);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic alignErr, rangeErr, timerWidthErr, timerCountErr;
    logic inDm, inTc0, inTc1, inIns, inTcCount;
    logic excAdes, stReady, enq, deq, memValid;

    logic [LSB-1:0]    laneOff;
    logic [LANES-1:0]  byteMask;
    logic [LANES-1:0]  byteEn;
    logic [DATA_W-1:0] laneData;
    logic [31:0]       alignedAddr;

    logic [PTR_W-1:0] rdPtr, wrPtr;
    logic [CNT_W-1:0] count;

    logic [31:0]       entAddr [DEPTH];
    logic [DATA_W-1:0] entData [DEPTH];
    logic [LANES-1:0]  entBe   [DEPTH];

    // Address windows; timers are word-only and their count registers are read-only.
    assign inDm      = bus.st_addr <= DM_END;
    assign inTc0     = (bus.st_addr >= TC0_BASE) && (bus.st_addr <= TC0_BASE + 32'hb);
    assign inTc1     = (bus.st_addr >= TC1_BASE) && (bus.st_addr <= TC1_BASE + 32'hb);
    assign inIns     = (bus.st_addr >= INS_BASE) && (bus.st_addr <= INS_BASE + 32'h3);
    assign inTcCount = ((bus.st_addr >= TC0_BASE + 32'h8) && (bus.st_addr <= TC0_BASE + 32'hb))
                    || ((bus.st_addr >= TC1_BASE + 32'h8) && (bus.st_addr <= TC1_BASE + 32'hb));

    assign rangeErr      = !(inDm || inTc0 || inTc1 || inIns);
    assign timerWidthErr = (inTc0 || inTc1) && (bus.st_size != 2'd2);
    assign timerCountErr = inTcCount;

    // NOTE: every signal assigned in always_comb gets a default first so no path infers a latch.
    always_comb begin
        alignErr = 1'b0;
        byteMask = '0;
        case (bus.st_size)
            2'd0: begin
                alignErr = 1'b0;
                byteMask = LANES'(1);
            end
            2'd1: begin
                alignErr = bus.st_addr[0];
                byteMask = LANES'(3);
            end
            2'd2: begin
                alignErr = bus.st_addr[1:0] != 2'b00;
                byteMask = LANES'(15);
            end
            default: begin
                alignErr = (DATA_W == 32) ? 1'b1 : (bus.st_addr[2:0] != 3'b000);
                byteMask = '1;
            end
        endcase
    end

    assign excAdes = bus.st_valid
                   & (alignErr | rangeErr | timerWidthErr | timerCountErr | bus.st_ovf);

    assign laneOff     = bus.st_addr[LSB-1:0];
    assign byteEn      = byteMask << laneOff;
    assign laneData    = bus.st_data << {laneOff, 3'b000};
    assign alignedAddr = {bus.st_addr[31:LSB], LSB'(0)};

    assign memValid = count != '0;
    assign stReady  = (count < CNT_W'(DEPTH)) & !bus.flush;
    assign enq      = bus.st_valid & stReady & !excAdes;
    assign deq      = memValid & bus.mem_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (bus.flush) begin
            // The offered head survives a flush; everything behind it is dropped.
            if (memValid) begin
                rdPtr <= rdPtr + PTR_W'(deq);
                wrPtr <= rdPtr + PTR_W'(1);
                count <= deq ? '0 : CNT_W'(1);
            end
        end else begin
            wrPtr <= wrPtr + PTR_W'(enq);
            rdPtr <= rdPtr + PTR_W'(deq);
            count <= count + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    // NOTE: entry storage is not reset; count marks which entries are live and
    // the bus outputs are forced to zero while nothing is offered.
    always_ff @(posedge clk) begin
        if (enq) begin
            entAddr[wrPtr] <= alignedAddr;
            entData[wrPtr] <= laneData;
            entBe[wrPtr]   <= byteEn;
        end
    end

    assign bus.st_ready   = stReady;
    assign bus.exc_ades   = excAdes;
    assign bus.mem_valid  = memValid;
    assign bus.mem_addr   = memValid ? entAddr[rdPtr] : '0;
    assign bus.mem_wdata  = memValid ? entData[rdPtr] : '0;
    assign bus.mem_byteen = memValid ? entBe[rdPtr]   : '0;
    assign bus.count      = count;
endmodule

// File: tb/tb_store_queue_be.sv
// Bench for store_queue_be: scoreboard of expected bus writes pushed at issue,
// popped and compared whenever the bus accepts the head entry.
module tb_store_queue_be;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    store_queue_be_if #(.DATA_W(32), .DEPTH(DEPTH)) sq ();
    store_queue_be_if #(.DATA_W(64), .DEPTH(DEPTH)) sq64 ();

    store_queue_be #(.DATA_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(sq.slave));
    store_queue_be #(.DATA_W(64), .DEPTH(DEPTH)) dut64 (
        .clk(clk), .reset(reset), .bus(sq64.slave));

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } sbEntry_t;

    sbEntry_t sb[$];
    int testsRun    = 0;
    int testsFailed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sq.st_valid = 1'b0;
        sq.st_size  = 2'd0;
        sq.st_addr  = '0;
        sq.st_data  = '0;
        sq.st_ovf   = 1'b0;
    endtask

    task automatic idle64();
        sq64.st_valid = 1'b0;
        sq64.st_size  = 2'd0;
        sq64.st_addr  = '0;
        sq64.st_data  = '0;
        sq64.st_ovf   = 1'b0;
    endtask

    // Drives one store for the current cycle; checks exc/ready and records the expected write.
    task automatic driveStore(input string tag, input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] data, input logic ovf, input logic expExc,
                              input logic expRdy, input logic [3:0] expBe,
                              input logic [31:0] expWdata);
        sq.st_valid = 1'b1;
        sq.st_size  = size;
        sq.st_addr  = addr;
        sq.st_data  = data;
        sq.st_ovf   = ovf;
        #1;
        check({tag, "_exc"}, sq.exc_ades, expExc);
        check({tag, "_rdy"}, sq.st_ready, expRdy);
        if (!expExc && expRdy)
            sb.push_back(sbEntry_t'{addr: {addr[31:2], 2'b00}, wdata: expWdata, be: expBe});
    endtask

    always @(negedge clk) begin : monitor
        sbEntry_t e;
        if (!reset && sq.mem_valid && sq.mem_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                check("bus_addr",  sq.mem_addr,   e.addr);
                check("bus_wdata", sq.mem_wdata,  e.wdata);
                check("bus_be",    sq.mem_byteen, e.be);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        idle64();
        sq.flush = 1'b0;
        sq.mem_ready = 1'b0;
        sq64.flush = 1'b0;
        sq64.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", sq.count, 0);
        check("rst_valid", sq.mem_valid, 0);
        check("rst_addr",  sq.mem_addr, 0);
        check("rst_wdata", sq.mem_wdata, 0);
        check("rst_be",    sq.mem_byteen, 0);
        reset = 1'b0;
        tick();

        // Single legal word store, 1-cycle latency, no bypass.
        sq.mem_ready = 1'b1;
        driveStore("sw10", 2'd2, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 4'hF, 32'hDEADBEEF);
        check("sw10_nobypass", sq.mem_valid, 0);
        tick();
        idle();
        check("sw10_valid", sq.mem_valid, 1);
        check("sw10_addr",  sq.mem_addr, 32'h10);
        check("sw10_be",    sq.mem_byteen, 4'hF);
        check("sw10_wdata", sq.mem_wdata, 32'hDEADBEEF);
        tick();
        check("sw10_drained", sq.count, 0);

        // Lane shifting.
        driveStore("sb7", 2'd0, 32'h7, 32'hAB, 1'b0, 1'b0, 1'b1, 4'h8, 32'hAB000000);
        tick();
        driveStore("sh2", 2'd1, 32'h2, 32'h1234, 1'b0, 1'b0, 1'b1, 4'hC, 32'h12340000);
        tick();
        idle();
        repeat (3) tick();
        check("lanes_drained", sq.count, 0);

        // Faulting stores never consume an entry; exc_ades ignores st_ready.
        sq.mem_ready = 1'b0;
        driveStore("exc_sh3",    2'd1, 32'h3,    32'h1, 1'b0, 1'b1, 1'b1, 4'h0, 32'h0);
        tick();
        driveStore("exc_sw3000", 2'd2, 32'h3000, 32'h1, 1'b0, 1'b1, 1'b1, 4'h0, 32'h0);
        tick();
        driveStore("exc_sb7f04", 2'd0, 32'h7f04, 32'h1, 1'b0, 1'b1, 1'b1, 4'h0, 32'h0);
        tick();
        driveStore("exc_sw7f18", 2'd2, 32'h7f18, 32'h1, 1'b0, 1'b1, 1'b1, 4'h0, 32'h0);
        tick();
        driveStore("exc_ovf",    2'd2, 32'h20,   32'h1, 1'b1, 1'b1, 1'b1, 4'h0, 32'h0);
        tick();
        driveStore("exc_sd32",   2'd3, 32'h0,    32'h1, 1'b0, 1'b1, 1'b1, 4'h0, 32'h0);
        tick();
        driveStore("exc_sb3000", 2'd0, 32'h3000, 32'h1, 1'b0, 1'b1, 1'b1, 4'h0, 32'h0);
        tick();
        idle();
        sq.st_addr = 32'h3000;
        sq.st_size = 2'd2;
        #1;
        check("exc_novalid", sq.exc_ades, 0);
        idle();
        check("exc_count", sq.count, 0);

        // Back-pressure with boundary-legal addresses, then in-order drain.
        driveStore("bp_tc0",   2'd2, 32'h7f00, 32'h11111111, 1'b0, 1'b0, 1'b1, 4'hF, 32'h11111111);
        tick();
        driveStore("bp_dmend", 2'd0, 32'h2fff, 32'h5A,       1'b0, 1'b0, 1'b1, 4'h8, 32'h5A000000);
        tick();
        driveStore("bp_ins",   2'd2, 32'h7f20, 32'h22223333, 1'b0, 1'b0, 1'b1, 4'hF, 32'h22223333);
        tick();
        driveStore("bp_sh",    2'd1, 32'h102,  32'hBEEF,     1'b0, 1'b0, 1'b1, 4'hC, 32'hBEEF0000);
        tick();
        driveStore("bp_over",  2'd2, 32'h200,  32'h44,       1'b0, 1'b0, 1'b0, 4'hF, 32'h44);
        tick();
        idle();
        check("bp_count", sq.count, DEPTH);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_hold_addr%0d", i),  sq.mem_addr,   sb[0].addr);
            check($sformatf("bp_hold_wdata%0d", i), sq.mem_wdata,  sb[0].wdata);
            check($sformatf("bp_hold_be%0d", i),    sq.mem_byteen, sb[0].be);
            tick();
        end
        sq.mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("bp_drain%0d", k), sq.count, 3 - k);
        end

        // Simultaneous traffic at full and at count=2.
        sq.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            driveStore($sformatf("fill%0d", i), 2'd2, 32'h300 + 32'(4 * i), 32'hA0 + 32'(i),
                       1'b0, 1'b0, 1'b1, 4'hF, 32'hA0 + 32'(i));
            tick();
        end
        idle();
        check("full_count", sq.count, 4);
        sq.mem_ready = 1'b1;
        driveStore("full_enq", 2'd2, 32'h400, 32'h99, 1'b0, 1'b0, 1'b0, 4'hF, 32'h99);
        tick();
        idle();
        check("full_deq_only", sq.count, 3);
        tick();
        check("c2_before", sq.count, 2);
        driveStore("c2_enq", 2'd2, 32'h404, 32'h77, 1'b0, 1'b0, 1'b1, 4'hF, 32'h77);
        tick();
        idle();
        check("c2_steady", sq.count, 2);
        repeat (2) tick();
        check("c2_drained", sq.count, 0);

        // Flush keeps the head only; no enqueue during flush.
        sq.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            driveStore($sformatf("fl%0d", i), 2'd2, 32'h500 + 32'(4 * i), 32'hF0 + 32'(i),
                       1'b0, 1'b0, 1'b1, 4'hF, 32'hF0 + 32'(i));
            tick();
        end
        idle();
        check("fl_count3", sq.count, 3);
        sq.flush = 1'b1;
        driveStore("fl_enq", 2'd2, 32'h50c, 32'h5, 1'b0, 1'b0, 1'b0, 4'hF, 32'h5);
        sb = sb[0:0];
        tick();
        sq.flush = 1'b0;
        idle();
        check("fl_count1", sq.count, 1);
        check("fl_head",   sq.mem_addr, 32'h500);
        sq.mem_ready = 1'b1;
        tick();
        check("fl_head_out", sq.count, 0);

        sq.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            driveStore($sformatf("flr%0d", i), 2'd2, 32'h600 + 32'(4 * i), 32'hE0 + 32'(i),
                       1'b0, 1'b0, 1'b1, 4'hF, 32'hE0 + 32'(i));
            tick();
        end
        idle();
        sq.flush = 1'b1;
        sq.mem_ready = 1'b1;
        sb = sb[0:0];
        tick();
        sq.flush = 1'b0;
        sq.mem_ready = 1'b0;
        check("flr_count0", sq.count, 0);

        sq.flush = 1'b1;
        tick();
        sq.flush = 1'b0;
        check("fle_count", sq.count, 0);
        check("fle_valid", sq.mem_valid, 0);
        driveStore("post_fl", 2'd2, 32'h700, 32'h3C3C3C3C, 1'b0, 1'b0, 1'b1, 4'hF, 32'h3C3C3C3C);
        tick();
        idle();
        check("post_fl_count", sq.count, 1);
        check("post_fl_addr",  sq.mem_addr, 32'h700);
        sq.mem_ready = 1'b1;
        tick();
        sq.mem_ready = 1'b0;
        check("post_fl_drain", sq.count, 0);

        // Reset mid-handshake.
        driveStore("rs0", 2'd2, 32'h800, 32'h1, 1'b0, 1'b0, 1'b1, 4'hF, 32'h1);
        tick();
        driveStore("rs1", 2'd2, 32'h804, 32'h2, 1'b0, 1'b0, 1'b1, 4'hF, 32'h2);
        tick();
        idle();
        check("rs_count2", sq.count, 2);
        reset = 1'b1;
        sq.mem_ready = 1'b1;
        sb.delete();
        tick();
        check("rs_count", sq.count, 0);
        check("rs_valid", sq.mem_valid, 0);
        check("rs_addr",  sq.mem_addr, 0);
        check("rs_be",    sq.mem_byteen, 0);
        reset = 1'b0;
        sq.mem_ready = 1'b0;
        tick();
        check("sb_drained", 64'(sb.size()), 0);

        // 64-bit bus: dword store and upper-lane word.
        sq64.st_valid = 1'b1;
        sq64.st_size  = 2'd3;
        sq64.st_addr  = 32'h8;
        sq64.st_data  = 64'h1122334455667788;
        #1;
        check("sd8_exc", sq64.exc_ades, 0);
        tick();
        idle64();
        check("sd8_addr",  sq64.mem_addr, 32'h8);
        check("sd8_be",    sq64.mem_byteen, 8'hFF);
        check("sd8_wdata", sq64.mem_wdata, 64'h1122334455667788);
        sq64.mem_ready = 1'b1;
        tick();
        check("sd8_drain", sq64.count, 0);
        sq64.st_valid = 1'b1;
        sq64.st_size  = 2'd2;
        sq64.st_addr  = 32'hC;
        sq64.st_data  = 64'hCAFEF00D;
        tick();
        idle64();
        check("swC_addr",  sq64.mem_addr, 32'h8);
        check("swC_be",    sq64.mem_byteen, 8'hF0);
        check("swC_wdata", sq64.mem_wdata, 64'hCAFEF00D_00000000);
        tick();
        check("swC_drain", sq64.count, 0);
        sq64.st_valid = 1'b1;
        sq64.st_size  = 2'd3;
        sq64.st_addr  = 32'h4;
        #1;
        check("sd4_exc", sq64.exc_ades, 1);
        tick();
        idle64();
        check("sd4_count", sq64.count, 0);
        sq64.mem_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
